ci_initiator: RTL and testbench

Initiator side of the custom-instruction (CI) handshake. It issues one CI transaction at a time, taking a command from a host port (CPU-model or test sequencer): it drives start, ciN, valueA and valueB to the CI responders, then waits for done. It captures the result, measures latency, and flags a timeout if no responder answers. It sits between the host and the shared CI bus that feeds responders such as the profiling counters.

---
 rtl/ci_initiator_if.sv | 33 +++
 rtl/ci_initiator.sv | 91 +++++++++
 tb/tb_ci_initiator.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ci_initiator_if.sv
// ci_initiator_if: host command/response and shared CI bus signals for one initiator.
interface ci_initiator_if #(
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_ci_n;
    logic [31:0]      req_value_a;
    logic [31:0]      req_value_b;
    logic             ci_start;
    logic [7:0]       ci_n;
    logic [31:0]      ci_value_a;
    logic [31:0]      ci_value_b;
    logic             ci_done;
    logic [31:0]      ci_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_timeout;
    logic [CNT_W-1:0] rsp_cycles;
    logic             busy;

    modport master (
        input  req_valid, req_ci_n, req_value_a, req_value_b, ci_done, ci_result, rsp_ready,
        output req_ready, ci_start, ci_n, ci_value_a, ci_value_b,
               rsp_valid, rsp_result, rsp_timeout, rsp_cycles, busy
    );
    modport slave (
        output req_valid, req_ci_n, req_value_a, req_value_b, ci_done, ci_result, rsp_ready,
        input  req_ready, ci_start, ci_n, ci_value_a, ci_value_b,
               rsp_valid, rsp_result, rsp_timeout, rsp_cycles, busy
    );
endinterface

// File: rtl/ci_initiator.sv
// ci_initiator: issues one custom-instruction transaction at a time and reports result, latency and timeout.
module ci_initiator #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    ci_initiator_if.master    bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [7:0]       ci_n_q, ci_n_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [31:0]      result_q, result_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ci_n_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            lat_q     <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            ci_n_q    <= ci_n_d;
            a_q       <= a_d;
            b_q       <= b_d;
            lat_q     <= lat_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            cycles_q  <= cycles_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ci_n_d    = ci_n_q;
        a_d       = a_q;
        b_d       = b_q;
        lat_d     = lat_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        cycles_d  = cycles_q;
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                state_d = ISSUE;
                ci_n_d  = bus.req_ci_n;
                a_d     = bus.req_value_a;
                b_d     = bus.req_value_b;
                lat_d   = CNT_W'(1);
            end
            // lat_q is 1 in ISSUE, so one rule covers ISSUE, WAIT and TIMEOUT==1
            ISSUE, WAIT: if (bus.ci_done) begin
                state_d   = RESP;
                result_d  = bus.ci_result;
                timeout_d = 1'b0;
                cycles_d  = lat_q;
            end else if (lat_q == CNT_W'(TIMEOUT)) begin
                state_d   = RESP;
                result_d  = '0;
                timeout_d = 1'b1;
                cycles_d  = lat_q;
            end else begin
                state_d = WAIT;
                lat_d   = lat_q + 1'b1;
            end
            RESP: state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    logic on_bus;
    assign on_bus          = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.req_ready   = state_q == IDLE;
    assign bus.busy        = state_q != IDLE;
    assign bus.ci_start    = state_q == ISSUE;
    assign bus.ci_n        = on_bus ? ci_n_q : '0;
    assign bus.ci_value_a  = on_bus ? a_q : '0;
    assign bus.ci_value_b  = on_bus ? b_q : '0;
    assign bus.rsp_valid   = state_q == RESP;
    assign bus.rsp_result  = result_q;
    assign bus.rsp_timeout = timeout_q;
    assign bus.rsp_cycles  = cycles_q;
endmodule

// File: tb/tb_ci_initiator.sv
// tb_ci_initiator: vector table, randomized model comparison and hand sequences for ci_initiator.
module tb_ci_initiator;
    localparam int T = 8;
    localparam int W = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    ci_initiator_if #(.CNT_W(W)) bus ();
    ci_initiator #(.TIMEOUT(T), .CNT_W(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  n;
        logic [31:0] a;
        logic [31:0] b;
        int          d;
        logic [31:0] res;
        logic [31:0] er;
        logic        et;
        int          ec;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Done d cycles after start (d<0: never) completes if it lands within TIMEOUT counted cycles.
    function automatic void model(input int d, input logic [31:0] res,
                                  output logic [31:0] er, output logic et, output int ec);
        if (d >= 0 && d < T) begin
            er = res; et = 1'b0; ec = d + 1;
        end else begin
            er = '0; et = 1'b1; ec = T;
        end
    endfunction

    task automatic txn(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b, input int d,
                       input logic [31:0] res, input logic [31:0] er, input logic et, input int ec);
        int k = 0;
        bus.req_valid   = 1'b1;
        bus.req_ci_n    = n;
        bus.req_value_a = a;
        bus.req_value_b = b;
        chk("req_ready_idle", {63'b0, bus.req_ready}, 64'd1);
        @(negedge clock);
        bus.req_valid   = 1'b0;
        bus.req_ci_n    = 8'($urandom);
        bus.req_value_a = $urandom;
        bus.req_value_b = $urandom;
        while (!bus.rsp_valid && k < 300) begin
            chk("ci_start", {63'b0, bus.ci_start}, {63'b0, k == 0});
            chk("ci_n_held", 64'(bus.ci_n), 64'(n));
            chk("ci_a_held", 64'(bus.ci_value_a), 64'(a));
            chk("ci_b_held", 64'(bus.ci_value_b), 64'(b));
            chk("busy_active", {63'b0, bus.busy & ~bus.req_ready}, 64'd1);
            bus.ci_done   = (k == d);
            bus.ci_result = (k == d) ? res : $urandom;
            @(negedge clock);
            k++;
        end
        bus.ci_done = 1'b0;
        chk("latency", 64'(k), 64'(ec));
        chk("rsp_valid", {63'b0, bus.rsp_valid}, 64'd1);
        chk("rsp_result", 64'(bus.rsp_result), 64'(er));
        chk("rsp_timeout", {63'b0, bus.rsp_timeout}, {63'b0, et});
        chk("rsp_cycles", 64'(bus.rsp_cycles), 64'(ec));
        chk("ci_bus_cleared", {bus.ci_value_a, bus.ci_value_b} | 64'(bus.ci_n), 64'd0);
        chk("ci_start_resp", {63'b0, bus.ci_start}, 64'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", {63'b0, bus.rsp_valid}, 64'd0);
        chk("busy_idle", {63'b0, bus.busy}, 64'd0);
    endtask

    initial begin
        vec_t        vt[6];
        logic [31:0] er;
        logic        et;
        int          ec;
        vt[0] = '{8'h00, 32'd1, 32'd0, 0, 32'hCAFE0001, 32'hCAFE0001, 1'b0, 1};
        vt[1] = '{8'h05, 32'hA5A5A5A5, 32'h0F0F0F0F, 3, 32'h12345678, 32'h12345678, 1'b0, 4};
        vt[2] = '{8'h07, 32'h11, 32'h22, -1, 32'h0, 32'h0, 1'b1, 8};
        vt[3] = '{8'h09, 32'h33, 32'h44, 2, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 3};
        vt[4] = '{8'h01, 32'h55, 32'h66, 7, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 8};
        vt[5] = '{8'h02, 32'h77, 32'h88, 8, 32'hFFFFFFFF, 32'h0, 1'b1, 8};
        bus.req_valid = 0; bus.req_ci_n = 0; bus.req_value_a = 0; bus.req_value_b = 0;
        bus.ci_done = 0; bus.ci_result = 0; bus.rsp_ready = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_req_ready", {63'b0, bus.req_ready}, 64'd1);
        chk("rst_busy", {63'b0, bus.busy}, 64'd0);
        chk("rst_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
        chk("rst_ci_start", {63'b0, bus.ci_start}, 64'd0);
        chk("rst_ci_bus", {bus.ci_value_a, bus.ci_value_b} | 64'(bus.ci_n), 64'd0);
        chk("rst_rsp", 64'(bus.rsp_result) | 64'(bus.rsp_cycles) | 64'(bus.rsp_timeout), 64'd0);

        foreach (vt[i]) txn(vt[i].n, vt[i].a, vt[i].b, vt[i].d, vt[i].res, vt[i].er, vt[i].et, vt[i].ec);

        for (int i = 0; i < 25; i++) begin
            int          d;
            logic [31:0] res;
            d   = int'($urandom_range(0, 11)) - 1;
            res = $urandom;
            model(d, res, er, et, ec);
            txn(8'($urandom), $urandom, $urandom, d, res, er, et, ec);
        end

        // Backpressure with req_valid held, plus a late done while in RESP.
        bus.req_valid = 1'b1; bus.req_ci_n = 8'h00; bus.req_value_a = 32'h1; bus.req_value_b = 32'h2;
        @(negedge clock);
        bus.ci_done = 1'b1; bus.ci_result = 32'hAAAA5555;
        @(negedge clock);
        bus.ci_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {63'b0, bus.rsp_valid}, 64'd1);
            chk("bp_rsp_result", 64'(bus.rsp_result), 64'hAAAA5555);
            chk("bp_rsp_cycles", 64'(bus.rsp_cycles), 64'd1);
            chk("bp_req_ready", {63'b0, bus.req_ready}, 64'd0);
            chk("bp_no_start", {63'b0, bus.ci_start}, 64'd0);
            bus.ci_done = (i == 2); bus.ci_result = 32'h5A5A5A5A;
            @(negedge clock);
            bus.ci_done = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        bus.req_value_a = 32'h99;
        chk("bp_idle_no_start", {63'b0, bus.ci_start}, 64'd0);
        chk("bp_idle_ready", {63'b0, bus.req_ready}, 64'd1);
        @(negedge clock);
        bus.req_valid = 1'b0;
        chk("bp_second_start", {63'b0, bus.ci_start}, 64'd1);
        chk("bp_second_a", 64'(bus.ci_value_a), 64'h99);
        bus.ci_done = 1'b1; bus.ci_result = 32'h600D;
        @(negedge clock);
        bus.ci_done = 1'b0;
        chk("bp_second_result", 64'(bus.rsp_result), 64'h600D);
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;

        // Reset during WAIT, then a spurious done in IDLE.
        bus.req_valid = 1'b1; bus.req_ci_n = 8'h3C; bus.req_value_a = 32'hF00; bus.req_value_b = 32'hBAA;
        @(negedge clock);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("mid_busy", {63'b0, bus.busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_start", {63'b0, bus.ci_start}, 64'd0);
        chk("rst_mid_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
        chk("rst_mid_busy", {63'b0, bus.busy}, 64'd0);
        chk("rst_mid_ci_bus", {bus.ci_value_a, bus.ci_value_b} | 64'(bus.ci_n), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.ci_done = (i == 1); bus.ci_result = 32'h77777777;
            @(negedge clock);
            bus.ci_done = 1'b0;
            chk("spur_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
            chk("spur_busy", {63'b0, bus.busy}, 64'd0);
            chk("spur_result", 64'(bus.rsp_result), 64'd0);
        end
        txn(8'h00, 32'd1, 32'd0, 0, 32'hCAFE0001, 32'hCAFE0001, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
